// File: rtl/ni_ejection_reassembler_if.sv
// Flit ingress and packet egress signals of the NI ejection reassembler.
// The slave modport is the reassembler itself. The master modport is the
// environment, which drives router flits and consumes packets.
interface ni_ejection_reassembler_if #(
  parameter int VC = 4
);
  localparam int VCW = $clog2(VC);

  // Router output channel (VC-time-multiplexed flits)
  logic [VCW-1:0] VCPlaneSelector;
  logic [31:0]    data_out;
  logic           valid_out;
  logic           ready_out;

  // Serialized packet stream
  logic [31:0]    pkt_data;
  logic           pkt_valid;
  logic           pkt_ready;
  logic [VCW-1:0] pkt_vc;
  logic           pkt_last;
  logic [7:0]     pkt_src;

  modport slave (
    input  VCPlaneSelector, data_out, valid_out, pkt_ready,
    output ready_out, pkt_data, pkt_valid, pkt_vc, pkt_last, pkt_src
  );

  modport master (
    output VCPlaneSelector, data_out, valid_out, pkt_ready,
    input  ready_out, pkt_data, pkt_valid, pkt_vc, pkt_last, pkt_src
  );
endinterface

// File: rtl/ni_ejection_reassembler.sv
// NI ejection reassembler.
// The block buffers router flits per VC and checks head/body/tail framing on
// each VC. It delivers only complete packets, store-and-forward, on one packet
// stream. VCs with a complete packet are served in round-robin order.
module ni_ejection_reassembler #(
  parameter int VC    = 4,
  parameter int DEPTH = 16,
  parameter int DIM   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  ni_ejection_reassembler_if.slave bus,
  output logic [VC-1:0]        err_flags,
  output logic [31:0]          pkt_count
);
  localparam int VCW = $clog2(VC);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;

  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  typedef enum logic { IN_IDLE, IN_PKT } in_state_t;
  typedef enum logic { ARB, SEND }       out_state_t;

  // Per-VC flit storage and framing state
  logic [31:0]   mem      [VC][DEPTH];
  logic [PW-1:0] wr_ptr   [VC];
  logic [PW-1:0] rd_ptr   [VC];
  logic [PW-1:0] complete [VC];   // tails currently held in each FIFO
  logic [VC-1:0] full;
  in_state_t     in_state [VC];
  in_state_t     in_next  [VC];
  logic [VC-1:0] wr_en, tail_wr, set_err;

  // Ingress handshake
  logic       accept;
  logic [1:0] ftype;

  // Output arbitration and delivery
  out_state_t     out_state, out_next;
  logic [VCW-1:0] gnt, gnt_next;
  logic [VCW-1:0] rr_ptr, rr_next;
  logic [7:0]     src_q, src_next;
  logic           hit;
  logic [VCW-1:0] hit_v;
  logic [VCW-1:0] idx;
  logic [3:0]     cand_row, cand_col;
  logic [7:0]     cand_src;
  logic [31:0]    front;
  logic           pop, tail_rd;

  // A FIFO is full when the pointers agree modulo DEPTH and differ in the wrap bit.
  always_comb begin
    for (int v = 0; v < VC; v++) begin
      full[v] = (wr_ptr[v][AW] != rd_ptr[v][AW]) &&
                (wr_ptr[v][AW-1:0] == rd_ptr[v][AW-1:0]);
    end
  end

  // A full FIFO stays not-ready even while it is being read, because there is no bypass path.
  assign bus.ready_out = rst & ~full[bus.VCPlaneSelector];
  assign accept        = bus.valid_out & bus.ready_out;
  assign ftype         = bus.data_out[31:30];

  // Per-VC framing check. It decides whether the selected VC stores or drops the flit.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    wr_en   = '0;
    tail_wr = '0;
    set_err = '0;
    for (int v = 0; v < VC; v++) begin
      in_next[v] = in_state[v];
      if (accept && (bus.VCPlaneSelector == VCW'(v))) begin
        case (in_state[v])
          IN_IDLE: begin
            if (ftype == FT_HEAD) begin
              wr_en[v]   = 1'b1;
              in_next[v] = IN_PKT;
            end else begin
              set_err[v] = 1'b1;
            end
          end
          IN_PKT: begin
            if (ftype == FT_BODY) begin
              wr_en[v] = 1'b1;
            end else if (ftype == FT_TAIL) begin
              wr_en[v]   = 1'b1;
              tail_wr[v] = 1'b1;
              in_next[v] = IN_IDLE;
            end else begin
              set_err[v] = 1'b1;
            end
          end
          default: in_next[v] = IN_IDLE;
        endcase
      end
    end
  end

  // Per-VC framing state, FIFO pointers and complete-packet counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC; v++) begin
        // NOTE: state registers use non-blocking assignments, so every reader sees the pre-edge value.
        in_state[v] <= IN_IDLE;
        wr_ptr[v]   <= '0;
        rd_ptr[v]   <= '0;
        complete[v] <= '0;
      end
    end else begin
      for (int v = 0; v < VC; v++) begin
        in_state[v] <= in_next[v];
        if (wr_en[v]) wr_ptr[v] <= wr_ptr[v] + PW'(1);
        if (pop && (gnt == VCW'(v))) rd_ptr[v] <= rd_ptr[v] + PW'(1);
        // A tail written and a tail read in the same cycle cancel out.
        if (tail_wr[v] && !(tail_rd && (gnt == VCW'(v))))
          complete[v] <= complete[v] + PW'(1);
        else if (!tail_wr[v] && tail_rd && (gnt == VCW'(v)))
          complete[v] <= complete[v] - PW'(1);
      end
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. The pointers define validity, and a reset-free array can map onto RAM.
    for (int v = 0; v < VC; v++) begin
      if (wr_en[v]) mem[v][wr_ptr[v][AW-1:0]] <= bus.data_out;
    end
  end

  // Round-robin search for a VC holding a complete packet. The search starts after the last grant.
  always_comb begin
    hit   = 1'b0;
    hit_v = '0;
    idx   = '0;
    for (int i = 1; i <= VC; i++) begin
      idx = VCW'((int'(rr_ptr) + i) % VC);
      if (!hit && (complete[idx] != '0)) begin
        hit   = 1'b1;
        hit_v = idx;
      end
    end
    cand_row = mem[hit_v][rd_ptr[hit_v][AW-1:0]][11:8];
    cand_col = mem[hit_v][rd_ptr[hit_v][AW-1:0]][15:12];
    cand_src = 8'(cand_row) * 8'(DIM) + 8'(cand_col);
  end

  // Output FSM state and grant registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_state <= ARB;
      gnt       <= '0;
      rr_ptr    <= VCW'(VC - 1);
      src_q     <= '0;
    end else begin
      out_state <= out_next;
      gnt       <= gnt_next;
      rr_ptr    <= rr_next;
      src_q     <= src_next;
    end
  end

  // Output FSM next state and packet stream outputs. The front flit falls through directly to pkt_data.
  always_comb begin
    out_next      = out_state;
    gnt_next      = gnt;
    rr_next       = rr_ptr;
    src_next      = src_q;
    front         = mem[gnt][rd_ptr[gnt][AW-1:0]];
    bus.pkt_valid = (out_state == SEND);
    bus.pkt_data  = bus.pkt_valid ? front : 32'd0;
    bus.pkt_last  = bus.pkt_valid && (front[31:30] == FT_TAIL);
    bus.pkt_vc    = gnt;
    bus.pkt_src   = src_q;
    pop           = bus.pkt_valid && bus.pkt_ready;
    tail_rd       = pop && bus.pkt_last;
    case (out_state)
      ARB: begin
        if (hit) begin
          out_next = SEND;
          gnt_next = hit_v;
          rr_next  = hit_v;
          src_next = cand_src;
        end
      end
      SEND: begin
        if (tail_rd) out_next = ARB;
      end
      default: out_next = ARB;
    endcase
  end

  // Sticky protocol errors and the delivered-packet counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_flags <= '0;
      pkt_count <= '0;
    end else begin
      err_flags <= err_flags | set_err;
      if (tail_rd) pkt_count <= pkt_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_ni_ejection_reassembler.sv
// Directed testbench for ni_ejection_reassembler.
// Every expected value below is worked out by hand from the flit encodings.
module tb_ni_ejection_reassembler;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  err_flags;
  logic [31:0] pkt_count;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  ni_ejection_reassembler_if #(.VC(4)) bus ();

  ni_ejection_reassembler #(.VC(4), .DEPTH(16), .DIM(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_flags (err_flags),
    .pkt_count (pkt_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one flit on a VC and hold it until it is accepted.
  task automatic send_flit(input logic [1:0] vc, input logic [31:0] d);
    int waited;
    waited = 0;
    bus.VCPlaneSelector = vc;
    bus.data_out        = d;
    bus.valid_out       = 1'b1;
    #1;
    while (!bus.ready_out && waited < 50) begin
      step();
      waited++;
    end
    if (!bus.ready_out) check("send_ready", 32'(bus.ready_out), 32'd1);
    step();
    bus.valid_out = 1'b0;
  endtask

  // Wait for the next presented flit and check it against the expected values. Then advance one cycle.
  task automatic expect_flit(input string tag, input logic [31:0] d, input logic [1:0] vc,
                             input logic [7:0] src, input int exp_wait);
    int waited;
    waited = 0;
    while (bus.pkt_valid !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    check({tag, "_wait"}, 32'(waited), 32'(exp_wait));
    check({tag, "_data"}, bus.pkt_data, d);
    check({tag, "_vc"},   32'(bus.pkt_vc), 32'(vc));
    check({tag, "_src"},  32'(bus.pkt_src), 32'(src));
    check({tag, "_last"}, 32'(bus.pkt_last), 32'(d[31:30] == 2'b11));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                 = 1'b0;
    bus.VCPlaneSelector = '0;
    bus.data_out        = '0;
    bus.valid_out       = 1'b0;
    bus.pkt_ready       = 1'b0;
    step(); step(); step();

    // Reset state
    check("rst_ready",  32'(bus.ready_out), 32'd0);
    check("rst_valid",  32'(bus.pkt_valid), 32'd0);
    check("rst_last",   32'(bus.pkt_last),  32'd0);
    check("rst_vc",     32'(bus.pkt_vc),    32'd0);
    check("rst_src",    32'(bus.pkt_src),   32'd0);
    check("rst_err",    32'(err_flags),     32'd0);
    check("rst_count",  pkt_count,          32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("post_rst_ready", 32'(bus.ready_out), 32'd1);

    // Single 3-flit packet on VC0. The source is row 0, column 1, so pkt_src is 1.
    bus.pkt_ready = 1'b1;
    send_flit(2'd0, 32'h4000_1021);
    send_flit(2'd0, 32'h8000_1021);
    send_flit(2'd0, 32'hC000_1021);
    expect_flit("t1_head", 32'h4000_1021, 2'd0, 8'd1, 1);
    expect_flit("t1_body", 32'h8000_1021, 2'd0, 8'd1, 0);
    expect_flit("t1_tail", 32'hC000_1021, 2'd0, 8'd1, 0);
    check("t1_idle",  32'(bus.pkt_valid), 32'd0);
    check("t1_count", pkt_count, 32'd1);

    // VC2 and VC1 packets interleave. VC1 completes first, and VC2 follows after a one-cycle gap.
    send_flit(2'd2, 32'h4000_3200);   // column 3, row 2 -> 9
    send_flit(2'd1, 32'h4000_2100);   // column 2, row 1 -> 5
    send_flit(2'd1, 32'hC000_2100);
    send_flit(2'd2, 32'hC000_3200);
    expect_flit("t2_vc1_head", 32'h4000_2100, 2'd1, 8'd5, 0);
    expect_flit("t2_vc1_tail", 32'hC000_2100, 2'd1, 8'd5, 0);
    expect_flit("t2_vc2_head", 32'h4000_3200, 2'd2, 8'd9, 1);
    expect_flit("t2_vc2_tail", 32'hC000_3200, 2'd2, 8'd9, 0);
    check("t2_count", pkt_count, 32'd3);

    // Round robin. VC3 is granted and stalls while VC2, VC0 and VC1 fill. The service order is then 3, 0, 1, 2.
    bus.pkt_ready = 1'b0;
    send_flit(2'd3, 32'h4000_F300);   // column 15, row 3 -> 24
    send_flit(2'd3, 32'hC000_F300);
    send_flit(2'd2, 32'h4000_0000);   // column 0, row 0 -> 0
    send_flit(2'd2, 32'hC000_0000);
    send_flit(2'd0, 32'h4000_A500);   // column 10, row 5 -> 25
    send_flit(2'd0, 32'hC000_A500);
    send_flit(2'd1, 32'h4000_1100);   // column 1, row 1 -> 4
    send_flit(2'd1, 32'hC000_1100);
    check("stall_valid", 32'(bus.pkt_valid), 32'd1);
    check("stall_data0", bus.pkt_data, 32'h4000_F300);
    step();
    check("stall_data1", bus.pkt_data, 32'h4000_F300);
    check("stall_vc",    32'(bus.pkt_vc), 32'd3);
    check("stall_src",   32'(bus.pkt_src), 32'd24);
    bus.pkt_ready = 1'b1;
    expect_flit("rr_vc3_head", 32'h4000_F300, 2'd3, 8'd24, 0);
    expect_flit("rr_vc3_tail", 32'hC000_F300, 2'd3, 8'd24, 0);
    expect_flit("rr_vc0_head", 32'h4000_A500, 2'd0, 8'd25, 1);
    expect_flit("rr_vc0_tail", 32'hC000_A500, 2'd0, 8'd25, 0);
    expect_flit("rr_vc1_head", 32'h4000_1100, 2'd1, 8'd4, 1);
    expect_flit("rr_vc1_tail", 32'hC000_1100, 2'd1, 8'd4, 0);
    expect_flit("rr_vc2_head", 32'h4000_0000, 2'd2, 8'd0, 1);
    expect_flit("rr_vc2_tail", 32'hC000_0000, 2'd2, 8'd0, 0);
    check("rr_count", pkt_count, 32'd7);

    // Protocol errors. A body flit on idle VC3 is dropped. A second head on busy VC2 is dropped.
    send_flit(2'd3, 32'h8000_0000);
    step(); step();
    check("err_vc3_flags", 32'(err_flags), 32'h8);
    check("err_vc3_valid", 32'(bus.pkt_valid), 32'd0);
    check("err_vc3_count", pkt_count, 32'd7);
    send_flit(2'd2, 32'h4000_7200);   // column 7, row 2 -> 13
    send_flit(2'd2, 32'h4000_5500);   // dropped
    check("err_vc2_flags", 32'(err_flags), 32'hC);
    send_flit(2'd2, 32'h8000_1234);
    send_flit(2'd2, 32'hC000_7200);
    expect_flit("err_vc2_head", 32'h4000_7200, 2'd2, 8'd13, 1);
    expect_flit("err_vc2_body", 32'h8000_1234, 2'd2, 8'd13, 0);
    expect_flit("err_vc2_tail", 32'hC000_7200, 2'd2, 8'd13, 0);
    check("err_vc2_count", pkt_count, 32'd8);

    // VC0 is filled with 16 flits and no tail. VC0 backpressures, but VC3 still accepts.
    bus.pkt_ready = 1'b0;
    send_flit(2'd0, 32'h4000_0000);
    for (int i = 1; i < 16; i++) send_flit(2'd0, 32'h8000_0000 | 32'(i));
    bus.VCPlaneSelector = 2'd0;
    #1;
    check("full_vc0_ready", 32'(bus.ready_out), 32'd0);
    bus.VCPlaneSelector = 2'd3;
    #1;
    check("full_vc3_ready", 32'(bus.ready_out), 32'd1);
    send_flit(2'd3, 32'h4000_0300);
    bus.pkt_ready = 1'b1;
    step(); step(); step(); step();
    check("full_no_drain", 32'(bus.pkt_valid), 32'd0);
    check("full_count",    pkt_count, 32'd8);
    bus.VCPlaneSelector = 2'd0;
    #1;
    check("full_vc0_still", 32'(bus.ready_out), 32'd0);

    // A partial packet on VC1 and a stalled packet on VC2 are both cut off by an asynchronous reset.
    bus.pkt_ready = 1'b0;
    send_flit(2'd1, 32'h4000_1100);
    send_flit(2'd1, 32'h8000_1100);
    send_flit(2'd2, 32'h4000_2300);   // column 2, row 3 -> 11
    send_flit(2'd2, 32'hC000_2300);
    step();
    check("pre_rst_valid", 32'(bus.pkt_valid), 32'd1);
    check("pre_rst_vc",    32'(bus.pkt_vc), 32'd2);
    check("pre_rst_src",   32'(bus.pkt_src), 32'd11);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.pkt_valid), 32'd0);
    check("mid_rst_last",  32'(bus.pkt_last), 32'd0);
    check("mid_rst_data",  bus.pkt_data, 32'd0);
    check("mid_rst_vc",    32'(bus.pkt_vc), 32'd0);
    check("mid_rst_src",   32'(bus.pkt_src), 32'd0);
    check("mid_rst_err",   32'(err_flags), 32'd0);
    check("mid_rst_count", pkt_count, 32'd0);
    check("mid_rst_ready", 32'(bus.ready_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // After reset, a clean VC1 packet is delivered. Nothing survives from the discarded partial packet.
    bus.pkt_ready = 1'b1;
    send_flit(2'd1, 32'h4000_1100);
    send_flit(2'd1, 32'hC000_1100);
    expect_flit("post_head", 32'h4000_1100, 2'd1, 8'd4, 1);
    expect_flit("post_tail", 32'hC000_1100, 2'd1, 8'd4, 0);
    check("post_count", pkt_count, 32'd1);
    check("post_err",   32'(err_flags), 32'd0);
    check("post_idle",  32'(bus.pkt_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ni_ejection_reassembler.md
Name: ni_ejection_reassembler

Overview:
Network-interface ejection stage that sits directly downstream of a router node's local output port. It accepts VC-time-multiplexed flits (data_out/valid_out/ready_out) and buffers them per VC. Each VC's packet stream is checked for head/body/tail protocol. Complete packets are then serialized, store-and-forward, onto a single packet stream with round-robin arbitration across VCs.

Parameters:
VC, 4, number of virtual channels / VC planes
DEPTH, 16, flits per VC FIFO; power of 2, must be >= longest packet
DIM, 3, mesh dimension used for node-index arithmetic
VCW, $clog2(VC), VC index width (derived, localparam)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
VCPlaneSelector  in  VCW  VC plane currently owning the router output channel
data_out  in  32  flit from router
valid_out  in  1  flit valid
ready_out  out  1  flit accepted when valid_out & ready_out
pkt_data  out  32  flit of packet being delivered
pkt_valid  out  1  pkt_data valid
pkt_ready  in  1  downstream consumer ready
pkt_vc  out  VCW  VC of packet being delivered
pkt_last  out  1  high with the tail flit
pkt_src  out  8  source node index of packet being delivered
err_flags  out  VC  sticky per-VC protocol error
pkt_count  out  32  packets fully delivered

Behaviour:
- Flit type is [31:30]: 01 head, 10 body, 11 tail, 00 invalid. Head/tail fields are [29:28] priority, [27:16] msg id, [15:12] src col, [11:8] src row, [7:4] dst col, [3:0] dst row.
- Reset (rst low, async): all FIFOs are emptied. All VC states go to IDLE, the output FSM goes to ARB, and the round-robin pointer goes to VC-1 (so VC0 wins first). ready_out=0 while rst is low. pkt_valid=0, pkt_last=0, pkt_vc=0, pkt_src=0, err_flags=0, pkt_count=0. Partial packets are discarded.
- ready_out = !full[VCPlaneSelector], combinational. There is no bypass: a full FIFO stays not-ready even when it is being read in the same cycle.
- Input VC FSM (per VC), with states IDLE and IN_PKT:
  - IDLE + head: write the flit, go to IN_PKT.
  - IDLE + body/tail/invalid: drop the flit, set err_flags[v].
  - IN_PKT + body: write the flit.
  - IN_PKT + tail: write the flit, increment complete[v], go to IDLE.
  - IN_PKT + head/invalid: drop the flit, set err_flags[v], stay in IN_PKT.
- The minimum packet is 2 flits (head + tail).
- Dropped flits are still handshaken (ready_out unaffected).
- complete[v] counts tails held in FIFO v. It increments on a tail write and decrements on a tail read; when both happen in the same cycle the net change is 0.
- Output FSM:
  - ARB: pkt_valid=0. Scan from rr_ptr+1 modulo VC for the first v with complete[v]>0. On a hit, register gnt=v, pkt_vc=v, and pkt_src = src_row*DIM + src_col taken from FIFO v's front flit (the head). Update rr_ptr=v and go to SEND. On a miss, stay in ARB.
  - SEND: pkt_valid=1 and pkt_data = front of FIFO gnt (first-word fall-through). pkt_last = (pkt_data[31:30]==11). A FIFO pop occurs on pkt_valid & pkt_ready. On popping the tail: pkt_count += 1 (wraps at 2^32), go to ARB.
- ARB costs exactly one bubble cycle between packets. Minimum latency from tail accept to head presented is 2 cycles.
- pkt_data, pkt_vc and pkt_src are held stable while pkt_valid & !pkt_ready.
- FIFO pointers are (log2 DEPTH + 1) bits wide; wrap-around is modulo DEPTH. Full means 16 entries at default.
- err_flags clears only on reset.

Test Plan:
- VC0 receives 0x40001021, 0x80001021, 0xC0001021 with pkt_ready=1 -> after the tail, pkt_valid for 3 cycles carrying the same words. pkt_vc=0, pkt_src=1, pkt_last only on 0xC0001021, pkt_count=1.
- Complete 2-flit packets land on VC2 and VC1 in the same window, pointer at reset -> delivered VC1 then VC2 with a one-cycle gap between. A following VC1 packet is delivered only after VC2 (round robin).
- pkt_ready=0; 16 flits of a packet (no tail yet) on VC0 -> ready_out=0 whenever VCPlaneSelector=0. VC3 flits are still accepted. Raising pkt_ready never drains VC0 until its tail arrives after space frees.
- Body 0x80000000 on idle VC3 -> flit dropped, err_flags=4'b1000, no output, pkt_count unchanged. Head arriving on VC2 while it is IN_PKT -> err_flags[2]=1, remaining packet still delivered intact.
- Head+body on VC1 with no tail -> never emitted. Assert rst low mid-stream -> all outputs 0 immediately. After release, a clean packet on VC1 is delivered with pkt_count=1.
